tiny_ram_ctrl: RTL and testbench

Parametrised successor of the core's 8-bit scratch RAM. Generic width and depth, a registered read with valid strobe, and a ready handshake. Includes a hardware clear engine that zero-fills the array after reset or on request, so that software never reads stale contents. It sits on the core data bus where the flat 256x8 RAM sits today, gated by the bus-decoder `select`.

---
 rtl/tiny_ram_pkg.sv | 15 +
 rtl/tiny_ram_array.sv | 29 ++
 rtl/tiny_ram_ctrl.sv | 104 ++++++++++
 tb/tb_tiny_ram_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tiny_ram_pkg.sv
// Shared types and helpers for the tiny_ram_ctrl scratch RAM.
// Holds the controller state encoding and the clear-counter width function.
package tiny_ram_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Index/counter width for a given depth; never narrower than one bit.
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tiny_ram_array.sv
// Plain word storage: one synchronous write port, one synchronous read port.
// A read and write to the same word on the same edge returns the old contents.
module tiny_ram_array
  import tiny_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  localparam int IDX_W = cnt_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tiny_ram_ctrl.sv
// Scratch RAM controller: bus handshake, range check, zero-on-idle read data
// and a clear engine that zero-fills the array after reset or on request.
module tiny_ram_ctrl
  import tiny_ram_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              select,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              ready,
  input  logic              clear,
  output logic              busy
);

  localparam int              CW       = cnt_width(DEPTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rvalid_q;
  logic            hit_q;

  logic            acc;
  logic            rd_acc;
  logic            in_range;
  logic            arr_we;
  logic [CW-1:0]   arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  // Handshake: a request is taken on any edge where ready, select and
  // read|write are all high; ready depends on the state register only.
  assign ready    = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_CLEAR);
  assign acc      = ready & select & (read | write);
  assign rd_acc   = acc & read;
  assign in_range = ({1'b0, addr} < DEPTH_L);

  assign arr_we    = busy | (acc & write & in_range);
  assign arr_waddr = busy ? cnt_q : addr[CW-1:0];
  assign arr_wdata = busy ? '0 : wdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rd_acc;
      hit_q    <= rd_acc & in_range;
    end
  end

  tiny_ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .re_i    (rd_acc & in_range),
    .raddr_i (addr[CW-1:0]),
    .rdata_o (arr_rdata)
  );

  // Out-of-range or absent reads drive zero so the shared OR-bus stays clean.
  assign rdata  = hit_q ? arr_rdata : '0;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_tiny_ram_ctrl.sv
// Directed bench for tiny_ram_ctrl: a 256-word instance with clear-on-reset
// and a 200-word instance without it, sharing one clock.
module tb_tiny_ram_ctrl;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, select, read, write, clear;
  logic [7:0]   addr;
  logic [W-1:0] wdata, rdata;
  logic         rvalid, ready, busy;

  logic         rst_b, select_b, read_b, write_b, clear_b;
  logic [7:0]   addr_b;
  logic [W-1:0] wdata_b, rdata_b;
  logic         rvalid_b, ready_b, busy_b;

  tiny_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .select(select), .read(read), .write(write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
    .ready(ready), .clear(clear), .busy(busy)
  );

  tiny_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .CLEAR_ON_RESET(0)) dut_b (
    .clk(clk), .rst(rst_b), .select(select_b), .read(read_b), .write(write_b),
    .addr(addr_b), .wdata(wdata_b), .rdata(rdata_b), .rvalid(rvalid_b),
    .ready(ready_b), .clear(clear_b), .busy(busy_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic sel, input logic rd, input logic wr,
                     input logic [7:0] a, input logic [W-1:0] d, input logic clr);
    select = sel; read = rd; write = wr; addr = a; wdata = d; clear = clr;
    step();
    select = 1'b0; read = 1'b0; write = 1'b0; clear = 1'b0;
  endtask

  task automatic bus_b(input logic sel, input logic rd, input logic wr,
                       input logic [7:0] a, input logic [W-1:0] d, input logic clr);
    select_b = sel; read_b = rd; write_b = wr; addr_b = a; wdata_b = d; clear_b = clr;
    step();
    select_b = 1'b0; read_b = 1'b0; write_b = 1'b0; clear_b = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [W-1:0] e);
    exp_q.push_back(e);
    bus(1'b1, 1'b1, 1'b0, a, '0, 1'b0);
    check({tag, ".data"}, rdata, exp_q.pop_front());
    check({tag, ".vld"}, rvalid, 1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 1000) begin
      step();
      n++;
    end
  endtask

  task automatic wait_idle_b(output int n);
    n = 0;
    while (busy_b && n < 1000) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1; select = 1'b0; read = 1'b0; write = 1'b0; clear = 1'b0;
    addr = '0; wdata = '0;
    rst_b = 1'b1; select_b = 1'b0; read_b = 1'b0; write_b = 1'b0; clear_b = 1'b0;
    addr_b = '0; wdata_b = '0;
    repeat (2) @(posedge clk);
    #1;

    check("rst.busy", busy, 1);
    check("rst.ready", ready, 0);
    check("rst.rvalid", rvalid, 0);
    check("rst.rdata", rdata, 0);
    check("rst_b.ready", ready_b, 1);
    check("rst_b.busy", busy_b, 0);

    // power-on clear lasts exactly DEPTH cycles
    rst = 1'b0; rst_b = 1'b0;
    wait_idle(n);
    check("por_clear_len", n, 256);
    check("por_ready", ready, 1);
    rd_chk("t1_rd7f", 8'h7F, 8'h00);

    // write then read, then idle zeroing
    bus(1'b1, 1'b0, 1'b1, 8'h10, 8'hA5, 1'b0);
    check("t2_wr.vld", rvalid, 0);
    rd_chk("t2_rd10", 8'h10, 8'hA5);
    step();
    check("t2_idle.data", rdata, 0);
    check("t2_idle.vld", rvalid, 0);
    bus(1'b0, 1'b1, 1'b0, 8'h10, '0, 1'b0);
    check("desel.vld", rvalid, 0);
    check("desel.data", rdata, 0);

    // read-during-write returns old data
    bus(1'b1, 1'b0, 1'b1, 8'h20, 8'h11, 1'b0);
    bus(1'b1, 1'b1, 1'b1, 8'h20, 8'h22, 1'b0);
    check("t3_rdw.data", rdata, 8'h11);
    check("t3_rdw.vld", rvalid, 1);
    rd_chk("t3_new", 8'h20, 8'h22);

    // DEPTH=200 instance: out-of-range write ignored, read returns zero
    bus_b(1'b1, 1'b0, 1'b1, 8'd199, 8'h3C, 1'b0);
    bus_b(1'b1, 1'b0, 1'b1, 8'hF0, 8'h55, 1'b0);
    bus_b(1'b1, 1'b1, 1'b0, 8'hF0, '0, 1'b0);
    check("t4_oor.data", rdata_b, 8'h00);
    check("t4_oor.vld", rvalid_b, 1);
    bus_b(1'b1, 1'b1, 1'b0, 8'd199, '0, 1'b0);
    check("t4_last.data", rdata_b, 8'h3C);
    check("t4_last.vld", rvalid_b, 1);
    bus_b(1'b0, 1'b0, 1'b0, 8'h00, '0, 1'b1);
    check("t4_clr.busy", busy_b, 1);
    wait_idle_b(n);
    check("t4_clear_len", n, 200);
    bus_b(1'b1, 1'b1, 1'b0, 8'd199, '0, 1'b0);
    check("t4_after_clr.data", rdata_b, 8'h00);

    // clear together with a write; a second pulse mid-fill is ignored
    bus(1'b1, 1'b0, 1'b1, 8'h05, 8'h99, 1'b1);
    check("t5.busy", busy, 1);
    check("t5.ready", ready, 0);
    repeat (50) step();
    bus(1'b1, 1'b1, 1'b0, 8'h05, '0, 1'b1);
    check("t5_rd_in_clr.vld", rvalid, 0);
    check("t5_rd_in_clr.data", rdata, 0);
    wait_idle(n);
    check("t5_clear_len", n + 51, 256);
    rd_chk("t5_rd05", 8'h05, 8'h00);

    // async reset zeroes read outputs immediately, then refills
    bus(1'b1, 1'b0, 1'b1, 8'h30, 8'h77, 1'b0);
    rd_chk("t6_pre", 8'h30, 8'h77);
    #2 rst = 1'b1;
    #1;
    check("t6_async.data", rdata, 0);
    check("t6_async.vld", rvalid, 0);
    check("t6_async.busy", busy, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_idle(n);
    check("t6_refill_len", n, 256);
    rd_chk("t6_rd30", 8'h30, 8'h00);

    // reset at clear cycle 100 restarts a full-length fill
    bus(1'b0, 1'b0, 1'b0, 8'h00, '0, 1'b1);
    repeat (99) step();
    rst = 1'b1;
    #1;
    check("t6b_rst.busy", busy, 1);
    check("t6b_rst.ready", ready, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_idle(n);
    check("t6b_restart_len", n, 256);
    check("t6b_ready", ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
